// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and sizing helpers for the serial pattern detector
package seq_det_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } seq_state_e;

  localparam int PAT_W_MAX = 16;

  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear (clear beats increment)
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-loadable serial pattern detector, Moore match pulse
// SEQ_MATCH_CNT_EN adds a saturating match counter; otherwise match_count is tied to 0.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic             mode_ovl,
  input  logic             cnt_clr,
  output logic             match,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = fill_width(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  seq_state_e       r_state;
  seq_state_e       w_state_n;
  logic [PAT_W-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] r_pat;
  logic             r_mode;
  logic             r_match;

  logic             w_accept;
  logic [PAT_W-1:0] w_hist_n;
  logic [FW-1:0]    w_fill_n;
  logic             w_full_n;
  logic             w_hit;

  // pat_load discards the bit offered on the same edge
  assign w_accept = in_valid & ~pat_load;
  assign w_hist_n = {r_hist[PAT_W-2:0], in_bit};
  assign w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + {{(FW-1){1'b0}}, 1'b1};
  assign w_full_n = (w_fill_n == FILL_FULL);
  assign w_hit    = w_accept & w_full_n & (w_hist_n == r_pat);

  always_comb begin
    w_state_n = r_state;
    if (pat_load) begin
      w_state_n = FILL;
    end else if (w_hit) begin
      w_state_n = HIT;
    end else if (w_accept && w_full_n) begin
      w_state_n = RUN;
    end else if (w_accept) begin
      w_state_n = FILL;
    end else if (r_state == HIT) begin
      w_state_n = r_mode ? RUN : FILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
      r_match <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= '0;
      r_mode  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_match <= (w_state_n == HIT);
      if (pat_load) begin
        r_hist <= '0;
        r_fill <= '0;
        r_pat  <= pat_value;
        r_mode <= mode_ovl;
      end else if (w_accept) begin
        // non-overlapping mode restarts the window after every match
        if (w_hit && !r_mode) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_n;
          r_fill <= w_fill_n;
        end
      end
    end
  end

  assign match   = r_match;
  assign state_o = r_state;

`ifdef SEQ_MATCH_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .clr   (cnt_clr),
    .count (match_count)
  );
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed bench with a queue-based reference model for seq_pattern_detector
module tb_seq_pattern_detector;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_MATCH_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_value = '0;
  logic             mode_ovl = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] match_count;

  seq_pattern_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .pat_load    (pat_load),
    .pat_value   (pat_value),
    .mode_ovl    (mode_ovl),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .state_o     (state_o),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: the bits accepted since the last flush, newest at the back
  bit               mq[$];
  logic [PAT_W-1:0] m_pat;
  bit               m_ovl;
  int               m_state;
  int               m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PAT_W-1:0] window();
    logic [PAT_W-1:0] w;
    w = '0;
    foreach (mq[i]) w = {w[PAT_W-2:0], mq[i]};
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pat   = '0;
    m_ovl   = 1'b1;
    m_state = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit hit;
    bit full;
    hit = 1'b0;
    if (pat_load) begin
      mq.delete();
      m_pat   = pat_value;
      m_ovl   = mode_ovl;
      m_state = 0;
    end else if (in_valid) begin
      mq.push_back(in_bit);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      full    = (mq.size() == PAT_W);
      hit     = full && (window() == m_pat);
      m_state = hit ? 2 : (full ? 1 : 0);
      if (hit && !m_ovl) mq.delete();
    end else if (m_state == 2) begin
      m_state = m_ovl ? 1 : 0;
    end
`ifdef SEQ_MATCH_CNT_EN
    if (cnt_clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
`endif
  endtask

  task automatic cyc(input bit v, input bit b, input bit clr);
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    @(posedge clk);
    model_step();
    #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic load(input logic [PAT_W-1:0] pv, input bit ovl, input bit v);
    pat_load  = 1'b1;
    pat_value = pv;
    mode_ovl  = ovl;
    cyc(v, 1'b1, 1'b1);
    pat_load  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_match", {31'd0, match}, (m_state == 2) ? 32'd1 : 32'd0);
      chk("model_state", {30'd0, state_o}, m_state);
      chk("model_count", {30'd0, match_count}, m_cnt);
    end
  end

  initial begin
    model_reset();
    #2;
    chk("reset_match", {31'd0, match}, 0);
    chk("reset_state", {30'd0, state_o}, 0);
    chk("reset_count", {30'd0, match_count}, 0);
    @(negedge clk);
    reset  = 1'b1;
    chk_on = 1'b1;

    // overlapping 1011 on 1,0,1,1,0,1,1
    load(4'b1011, 1'b1, 1'b0);
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("t1_first_hit", {31'd0, match}, 1);
    cyc(1, 0, 0);
    chk("t1_gap", {31'd0, match}, 0);
    cyc(1, 1, 0); cyc(1, 1, 0);
    chk("t1_second_hit", {31'd0, match}, 1);
    chk("t1_count", {30'd0, match_count}, CNT_ON ? 2 : 0);

    // same stream, non-overlapping
    load(4'b1011, 1'b0, 1'b0);
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("t2_hit", {31'd0, match}, 1);
    chk("t2_count", {30'd0, match_count}, CNT_ON ? 1 : 0);
    cyc(1, 0, 0);
    chk("t2_state_fill", {30'd0, state_o}, 0);
    cyc(1, 1, 0); cyc(1, 1, 0);
    chk("t2_no_second", {31'd0, match}, 0);

    // 1111 overlapping on six ones, then idle
    load(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0);
      chk("t3_ones", {31'd0, match}, (i >= 3) ? 1 : 0);
    end
    cyc(0, 0, 0);
    chk("t3_idle_drop", {31'd0, match}, 0);
    chk("t3_idle_run", {30'd0, state_o}, 1);

    // 0110 with an idle gap inside the pattern
    load(4'b0110, 1'b1, 1'b0);
    cyc(1, 0, 0); cyc(1, 1, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("t4_before", {31'd0, match}, 0);
    cyc(1, 0, 0);
    chk("t4_hit", {31'd0, match}, 1);

    // pat_load with a valid bit discards it and flushes the window
    load(4'b1011, 1'b1, 1'b0);
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    load(4'b1011, 1'b1, 1'b1);
    chk("t5_state", {30'd0, state_o}, 0);
    chk("t5_match", {31'd0, match}, 0);
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
    chk("t5_partial", {31'd0, match}, 0);
    cyc(1, 1, 0);
    chk("t5_hit", {31'd0, match}, 1);

    // saturation, clear-vs-hit, async reset in HIT
    load(4'b1111, 1'b1, 1'b0);
    repeat (8) cyc(1, 1, 0);
    chk("t6_saturate", {30'd0, match_count}, CNT_ON ? 3 : 0);
    cyc(1, 1, 1);
    chk("t6_clr_wins", {30'd0, match_count}, 0);
    chk("t6_clr_match", {31'd0, match}, 1);
    cyc(1, 1, 0);
    chk("t6_after_clr", {30'd0, match_count}, CNT_ON ? 1 : 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_match", {31'd0, match}, 0);
    chk("t6_rst_count", {30'd0, match_count}, 0);
    chk("t6_rst_state", {30'd0, state_o}, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (4) cyc(1, 1, 0);
    chk("t6_post_reset", {31'd0, match}, 0);
    cyc(0, 0, 0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
